// File: rtl/mdr_mem_if.sv
// Memory data register with a single-beat ready-based memory handshake engine.
// Optional wait-state timeout enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_if #(
    parameter int unsigned          DATA_W    = 32,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    parameter int unsigned          TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mdr_in,
    input  logic [DATA_W-1:0]     bus_in,
    input  logic                  rd_start,
    input  logic                  wr_start,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic                  err_clr,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mdr_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned NB = DATA_W / 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_be;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] w_rd_merge;
    logic              w_timeout;

`ifdef MDR_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_err;
    logic             w_waiting;

    assign w_waiting  = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_cnt_next = r_cnt + 1'b1;
    // Abort on the edge where the post-increment count reaches TIMEOUT.
    assign w_timeout  = w_waiting && !mem_ready && (w_cnt_next == CNT_W'(TIMEOUT));

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_waiting && !mem_ready) begin
                r_cnt <= w_cnt_next;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign w_unused  = err_clr | (TIMEOUT == 0);
    assign err       = 1'b0;
`endif

    always_comb begin
        w_rd_merge = r_mdr;
        for (int unsigned i = 0; i < NB; i++) begin
            if (r_be[i]) begin
                w_rd_merge[8*i +: 8] = mem_rdata[8*i +: 8];
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_mdr    <= RESET_VAL;
            r_wdata  <= '0;
            r_be     <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd_start) begin
                        r_state  <= S_RD_WAIT;
                        r_mem_rd <= 1'b1;
                        r_be     <= byte_en;
                        r_busy   <= 1'b1;
                    end else if (wr_start) begin
                        r_state  <= S_WR_WAIT;
                        r_mem_wr <= 1'b1;
                        r_wdata  <= r_mdr;
                        r_busy   <= 1'b1;
                    end else if (mdr_in) begin
                        r_mdr <= bus_in;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_ready) begin
                        r_mdr    <= w_rd_merge;
                        r_mem_rd <= 1'b0;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end else if (w_timeout) begin
                        r_mem_rd <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_ready) begin
                        r_mem_wr <= 1'b0;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end else if (w_timeout) begin
                        r_mem_wr <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_wdata;
    assign mdr_out   = r_mdr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Bench for mdr_mem_if: directed scenarios plus random traffic against a
// transaction-level reference model (timeout scenarios need MDR_TIMEOUT_EN).
module tb_mdr_mem_if;

    localparam logic [31:0] RV  = 32'hC0FF_EE11;
    localparam int          TMO = 4;

    logic        clk = 1'b1;
    logic        reset, mdr_in, rd_start, wr_start, err_clr, mem_ready;
    logic [31:0] bus_in, mem_rdata;
    logic [3:0]  byte_en;
    logic        mem_rd, mem_wr, busy, done, err;
    logic [31:0] mem_wdata, mdr_out;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_mdr, m_wdata, mask;
    logic [3:0]  m_be;
    logic        m_rd, m_wr, m_busy, m_done, m_err, m_is_rd;
    int          m_phase;   // 0 no transaction, 1 waiting on memory, 2 completion cycle
    int          m_waited;

    mdr_mem_if #(.DATA_W(32), .RESET_VAL(RV), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .mdr_in(mdr_in), .bus_in(bus_in),
        .rd_start(rd_start), .wr_start(wr_start), .byte_en(byte_en),
        .err_clr(err_clr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            m_mdr = RV; m_wdata = '0; m_rd = 0; m_wr = 0; m_busy = 0;
            m_done = 0; m_err = 0; m_phase = 0; m_waited = 0;
        end else begin
            m_done = 0;
`ifdef MDR_TIMEOUT_EN
            if (err_clr) m_err = 0;
`endif
            case (m_phase)
                0: begin
                    if (rd_start) begin
                        m_phase = 1; m_is_rd = 1; m_be = byte_en; m_rd = 1;
                        m_busy = 1; m_waited = 0;
                    end else if (wr_start) begin
                        m_phase = 1; m_is_rd = 0; m_wr = 1; m_wdata = m_mdr;
                        m_busy = 1; m_waited = 0;
                    end else if (mdr_in) begin
                        m_mdr = bus_in;
                    end
                end
                1: begin
                    if (mem_ready) begin
                        if (m_is_rd)
                            for (int i = 0; i < 4; i++)
                                if (m_be[i]) begin
                                    mask  = 32'hFF << (8 * i);
                                    m_mdr = (m_mdr & ~mask) | (mem_rdata & mask);
                                end
                        m_rd = 0; m_wr = 0; m_phase = 2; m_done = 1;
                    end else begin
                        m_waited++;
`ifdef MDR_TIMEOUT_EN
                        if (m_waited == TMO) begin
                            m_rd = 0; m_wr = 0; m_phase = 0; m_busy = 0; m_err = 1;
                        end
`endif
                    end
                end
                default: begin
                    m_phase = 0; m_busy = 0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("mdr_out", 64'(mdr_out), 64'(m_mdr));
        check("mem_rd", 64'(mem_rd), 64'(m_rd));
        check("mem_wr", 64'(mem_wr), 64'(m_wr));
        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        check_model();
    endtask

    task automatic quiet();
        mdr_in = 0; rd_start = 0; wr_start = 0; err_clr = 0; mem_ready = 0;
        bus_in = '0; mem_rdata = '0; byte_en = '0;
    endtask

    task automatic load(input logic [31:0] v);
        quiet(); mdr_in = 1; bus_in = v;
        step();
        quiet();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        reset = 0;
        step(); step();
        reset = 1;
        step();
        check("rst_mdr", 64'(mdr_out), 64'(RV));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdwr", 64'({mem_rd, mem_wr}), 64'd0);

        // bus load
        load(32'hDEADBEEF);
        check("ld_mdr", 64'(mdr_out), 64'hDEADBEEF);
        check("ld_nodone", 64'({done, mem_rd}), 64'd0);

        // byte-masked read with one wait edge
        load(32'hFFFFFFFF);
        rd_start = 1; byte_en = 4'b0101;
        step();
        quiet();
        check("rd_req", 64'({mem_rd, busy}), 64'b11);
        step();
        mem_ready = 1; mem_rdata = 32'h12345678;
        step();
        quiet();
        check("rd_mdr", 64'(mdr_out), 64'hFF34FF78);
        check("rd_done", 64'({done, mem_rd}), 64'b10);
        step();
        check("rd_done_end", 64'({done, busy}), 64'd0);

        // write, bus load attempts ignored while busy
        load(32'hA5A5A5A5);
        wr_start = 1;
        step();
        quiet(); mdr_in = 1; bus_in = 32'h11111111;
        check("wr_req", 64'({mem_wr, mem_wdata}), {31'd0, 1'b1, 32'hA5A5A5A5});
        mem_ready = 1;
        step();
        quiet();
        check("wr_done", 64'({done, mem_wr}), 64'b10);
        check("wr_mdr", 64'(mdr_out), 64'hA5A5A5A5);
        step();

        // simultaneous starts: read wins
        rd_start = 1; wr_start = 1; mdr_in = 1; bus_in = 32'h0; byte_en = 4'hF;
        step();
        quiet();
        check("pri_rd", 64'({mem_rd, mem_wr}), 64'b10);
        check("pri_mdr", 64'(mdr_out), 64'hA5A5A5A5);
        mem_ready = 1; mem_rdata = 32'h0BADCAFE;
        step();
        quiet();
        check("pri_done_mdr", 64'(mdr_out), 64'h0BADCAFE);
        step();

        // reset during a read
        rd_start = 1; byte_en = 4'hF;
        step();
        quiet();
        reset = 0;
        step();
        reset = 1;
        check("rstmid_mdr", 64'(mdr_out), 64'(RV));
        check("rstmid_rd", 64'({mem_rd, busy}), 64'd0);
        step();

`ifdef MDR_TIMEOUT_EN
        load(32'h5555AAAA);
        rd_start = 1; byte_en = 4'hF;
        step();
        quiet();
        for (int k = 1; k <= TMO; k++) begin
            step();
            if (k < TMO) check("tmo_pending", 64'({err, mem_rd}), 64'b01);
        end
        check("tmo_err", 64'({err, mem_rd, done, busy}), 64'b1000);
        check("tmo_mdr", 64'(mdr_out), 64'h5555AAAA);
        err_clr = 1;
        step();
        quiet();
        check("tmo_clr", 64'(err), 64'd0);
        wr_start = 1; err_clr = 1;
        step();
        wr_start = 0;
        for (int k = 1; k <= TMO; k++) step();
        check("tmo_setwins", 64'({err, mem_wr}), 64'b10);
        quiet();
        step();
`endif

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rd_start  = ($urandom_range(0, 4) == 0);
            wr_start  = ($urandom_range(0, 4) == 0);
            mdr_in    = ($urandom_range(0, 2) == 0);
            bus_in    = $urandom;
            byte_en   = 4'($urandom);
            mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 2) == 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 63) != 0);
`ifndef MDR_TIMEOUT_EN
            if (m_phase == 1 && m_waited > 8) mem_ready = 1;
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
